// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor and enable in, coin code, reject, busy and
// accepted-coin count out. The vending side (or a bench) uses master; the
// acceptor uses slave.
interface coin_acceptor_if;
  logic       sensor;
  logic       enable;
  logic [1:0] coinn;
  logic       reject;
  logic       busy;
  logic [7:0] acc_cnt;

  modport master (
    output sensor,
    output enable,
    input  coinn,
    input  reject,
    input  busy,
    input  acc_cnt
  );

  modport slave (
    input  sensor,
    input  enable,
    output coinn,
    output reject,
    output busy,
    output acc_cnt
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces the coin-path sensor, measures
// how long each coin blocks the path and classifies it as 5rs, 10rs or
// reject. Coins arriving too soon after the previous one, or while the
// vending side was not accepting at the moment the coin arrived, are
// rejected. Accepted coins are counted in a saturating 8-bit counter.
module coin_acceptor #(
  parameter int DEBOUNCE = 3,
  parameter int W5_MIN   = 8,
  parameter int W5_MAX   = 15,
  parameter int W10_MIN  = 20,
  parameter int W10_MAX  = 31,
  parameter int GAP      = 16,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        reset,
  coin_acceptor_if.slave bus
);

  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int GAP_W = $clog2(GAP + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);
  localparam logic [CNT_W-1:0] WIDTH_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] W5_LO     = CNT_W'(W5_MIN);
  localparam logic [CNT_W-1:0] W5_HI     = CNT_W'(W5_MAX);
  localparam logic [CNT_W-1:0] W10_LO    = CNT_W'(W10_MIN);
  localparam logic [CNT_W-1:0] W10_HI    = CNT_W'(W10_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_CLASSIFY,
    ST_GAP
  } state_t;

  // Width counter increment that sticks at all-ones; a stuck width means
  // the coin was longer than we can measure and is always rejected.
  function automatic logic [CNT_W-1:0] sat_width(input logic [CNT_W-1:0] w);
    return (w == WIDTH_MAX) ? w : w + 1'b1;
  endfunction

  // Accepted-coin counter increment that holds at 255.
  function automatic logic [7:0] sat_acc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Coin code for a finished measurement; 00 means the coin is rejected.
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] w,
                                          input logic             forced);
    if (forced || (w == WIDTH_MAX)) return 2'b00;
    if ((w >= W5_LO) && (w <= W5_HI)) return 2'b01;
    if ((w >= W10_LO) && (w <= W10_HI)) return 2'b10;
    return 2'b00;
  endfunction

  logic             sync_p0;
  logic             sync_p1;
  logic             level_p2;
  logic [DEB_W-1:0] deb_cnt;

  state_t           state;
  logic [CNT_W-1:0] width;
  logic [GAP_W-1:0] gap_cnt;
  logic             force_rej;
  logic [1:0]       coinn_r;
  logic             reject_r;
  logic             busy_r;
  logic [7:0]       acc_r;
  logic [1:0]       verdict;

  assign verdict     = classify(width, force_rej);
  assign bus.coinn   = coinn_r;
  assign bus.reject  = reject_r;
  assign bus.busy    = busy_r;
  assign bus.acc_cnt = acc_r;

  // Stage p0/p1: two-flop synchronizer for the asynchronous sensor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.sensor;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: filtered level follows the synchronized sensor only after it
  // has disagreed for DEBOUNCE consecutive samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_p2 <= 1'b0;
      deb_cnt  <= '0;
    end else if (sync_p1 == level_p2) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      level_p2 <= sync_p1;
      deb_cnt  <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Coin FSM with registered outputs; reset lands in GAP so a settle
  // period of filtered-low cycles precedes the first accepted coin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_GAP;
      width     <= '0;
      gap_cnt   <= '0;
      force_rej <= 1'b0;
      coinn_r   <= 2'b00;
      reject_r  <= 1'b0;
      busy_r    <= 1'b1;
      acc_r     <= 8'd0;
    end else begin
      coinn_r  <= 2'b00;
      reject_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (level_p2) begin
            state     <= ST_MEASURE;
            width     <= CNT_W'(1);
            force_rej <= !bus.enable;
            busy_r    <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (level_p2) begin
            width <= sat_width(width);
          end else begin
            state <= ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          coinn_r  <= verdict;
          reject_r <= (verdict == 2'b00);
          if (verdict != 2'b00) begin
            acc_r <= sat_acc(acc_r);
          end
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (level_p2) begin
            // A new coin before the gap elapsed is too close: reject it.
            state     <= ST_MEASURE;
            width     <= CNT_W'(1);
            force_rej <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) begin
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_GAP;
          busy_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEBOUNCE  3   consecutive stable synchronized samples required to change the filtered level
  W5_MIN    8   minimum pulse width, in cycles, classified as a 5rs coin
  W5_MAX    15  maximum pulse width classified as a 5rs coin
  W10_MIN   20  minimum pulse width classified as a 10rs coin
  W10_MAX   31  maximum pulse width classified as a 10rs coin
  GAP       16  filtered-low cycles required between coins
  CNT_W     6   width of the pulse-width counter
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk        in   1  single clock, rising edge
  reset      in   1  asynchronous, active-low reset
  sensor     in   1  raw coin-path sensor, high while a coin passes; asynchronous to clk
  enable     in   1  high when the downstream vending FSM accepts coins
  coinn      out  2  coin code: 01 = 5rs, 10 = 10rs, 00 = none; valid for one cycle only
  reject     out  1  one-cycle pulse that routes the coin to the return chute
  busy       out  1  high whenever the state is not IDLE
  acc_cnt    out  8  count of accepted coins, saturating at 255
REQ-003 coinn SHALL NOT take the value 11.

Function
REQ-004 sensor SHALL pass through a 2-flop synchronizer before any other use.
REQ-005 The filtered level SHALL change only after DEBOUNCE consecutive synchronized samples differ from it. Shorter glitches SHALL be ignored.
REQ-006 The states SHALL be IDLE, MEASURE, CLASSIFY and GAP.
REQ-007 IDLE: on a filtered rise, go to MEASURE with width = 1. At the same time, latch force_rej = !enable.
REQ-008 MEASURE: width increments by 1 on each cycle the filtered level stays high.
  - The counter saturates at 2^CNT_W-1.
  - A filtered fall moves the FSM to CLASSIFY.
REQ-009 CLASSIFY lasts one cycle, then the FSM enters GAP with the gap counter at 0. On that transition it registers exactly one of:
  - coinn = 01 if width is in [W5_MIN, W5_MAX] and force_rej = 0
  - coinn = 10 if width is in [W10_MIN, W10_MAX] and force_rej = 0
  - reject = 1 in every other case, including a saturated width
REQ-010 coinn and reject SHALL be high only during the first GAP cycle and SHALL never be asserted together.
REQ-011 acc_cnt SHALL increment in the same cycle coinn is nonzero and SHALL hold at 255 once reached.
REQ-012 GAP: the gap counter increments each filtered-low cycle.
  - When it reaches GAP, the FSM returns to IDLE.
  - A filtered rise during GAP goes to MEASURE with width = 1 and force_rej = 1 (coin too close).
REQ-013 enable SHALL be sampled only at the filtered rise. Later changes to enable SHALL NOT affect the coin being measured.
REQ-014 For a clean pulse of N cycles, width SHALL equal N.
REQ-015 Latency: coinn or reject SHALL assert 2 + DEBOUNCE + 2 cycles after the raw falling edge, give or take one cycle for synchronizer phase.

Reset
REQ-016 While reset = 0, the following SHALL clear immediately, independent of clk:
  - synchronizer flops, filtered level, width, gap counter, force_rej
  - coinn = 00, reject = 0, acc_cnt = 0
REQ-017 Reset SHALL put the FSM in GAP with the gap counter at 0, so busy = 1 after reset. GAP filtered-low cycles are needed before the first coin is accepted.
REQ-018 A coin already present at reset release SHALL be measured under force_rej = 1 and rejected.
REQ-019 Reset asserted mid-pulse SHALL abort the measurement with no coinn or reject pulse.

Verification
REQ-020 Release reset, 20 low cycles, enable = 1, 10-cycle pulse -> single coinn = 01 pulse; acc_cnt = 1; busy returns to 0 after 16 low cycles.
REQ-021 25-cycle pulse -> single coinn = 10 pulse. 17-cycle pulse -> single reject pulse with coinn = 00. 40-cycle pulse -> reject.
REQ-022 2-cycle glitch -> no coinn, no reject, FSM stays IDLE.
REQ-023 Two 10-cycle pulses separated by 5 low cycles -> coinn = 01 for the first, reject for the second; acc_cnt increases by exactly 1.
REQ-024 enable = 0 at the rise of a 10-cycle pulse, enable = 1 mid-pulse -> reject, acc_cnt unchanged.
REQ-025 reset low in the middle of a 25-cycle pulse -> outputs 00/0/0 immediately; no pulse after release; sensor high at release -> reject.
REQ-026 260 valid coins -> acc_cnt = 255.
